// File: rtl/path_tracer.sv
// Back-tracer for the shortest-path engine: snapshots distance/parent arrays on start,
// then streams node indices from dest back to src over a valid/ready handshake.
module path_tracer #(
  parameter int unsigned N_NODES  = 9,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned DIST_W   = 8,
  parameter int unsigned INF_DIST = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W-1:0]          src,
  input  logic [IDX_W-1:0]          dest,
  input  logic [N_NODES*IDX_W-1:0]  parent_flat,
  input  logic [N_NODES*DIST_W-1:0] dist_flat,
  output logic                      busy,
  output logic                      node_valid,
  input  logic                      node_ready,
  output logic [IDX_W-1:0]          node_id,
  output logic                      node_last,
  output logic                      done,
  output logic [IDX_W-1:0]          path_len,
  output logic [DIST_W-1:0]         total_dist,
  output logic                      err_unreachable,
  output logic                      err_loop
);

  typedef enum logic [1:0] {StIdle, StCheck, StEmit, StFinish} state_e;

  localparam logic [IDX_W-1:0]  NodesIdx = IDX_W'(N_NODES);
  localparam logic [DIST_W-1:0] InfDist  = DIST_W'(INF_DIST);
  localparam logic [IDX_W-1:0]  OneIdx   = IDX_W'(1);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            src_q, src_d;
  logic [IDX_W-1:0]            dest_q, dest_d;
  logic [N_NODES*IDX_W-1:0]    parent_q, parent_d;
  logic [N_NODES*DIST_W-1:0]   dist_q, dist_d;
  logic [IDX_W-1:0]            cur_q, cur_d;
  logic [IDX_W-1:0]            path_len_q, path_len_d;
  logic [DIST_W-1:0]           total_dist_q, total_dist_d;
  logic                        err_unr_q, err_unr_d;
  logic                        err_loop_q, err_loop_d;

  logic [IDX_W-1:0]            parent_arr [N_NODES];
  logic [DIST_W-1:0]           dist_arr   [N_NODES];
  logic [DIST_W-1:0]           dist_dest;
  logic [IDX_W-1:0]            nxt;
  logic [IDX_W-1:0]            len_inc;

  for (genvar i = 0; i < N_NODES; i++) begin : g_unpack
    assign parent_arr[i] = parent_q[i*IDX_W +: IDX_W];
    assign dist_arr[i]   = dist_q[i*DIST_W +: DIST_W];
  end

  // Out-of-range dest is flagged in CHECK; the guard only keeps the lookup well defined.
  assign dist_dest = (dest_q < NodesIdx) ? dist_arr[dest_q] : '0;
  assign nxt       = parent_arr[cur_q];
  assign len_inc   = path_len_q + OneIdx;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dest_d       = dest_q;
    parent_d     = parent_q;
    dist_d       = dist_q;
    cur_d        = cur_q;
    path_len_d   = path_len_q;
    total_dist_d = total_dist_q;
    err_unr_d    = err_unr_q;
    err_loop_d   = err_loop_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d        = src;
          dest_d       = dest;
          parent_d     = parent_flat;
          dist_d       = dist_flat;
          path_len_d   = '0;
          total_dist_d = '0;
          err_unr_d    = 1'b0;
          err_loop_d   = 1'b0;
          state_d      = StCheck;
        end
      end
      StCheck: begin
        if (src_q >= NodesIdx || dest_q >= NodesIdx || dist_dest >= InfDist) begin
          err_unr_d = 1'b1;
          state_d   = StFinish;
        end else begin
          total_dist_d = dist_dest;
          cur_d        = dest_q;
          state_d      = StEmit;
        end
      end
      StEmit: begin
        if (node_ready) begin
          path_len_d = len_inc;
          if (cur_q == src_q) begin
            state_d = StFinish;
          end else if (nxt >= NodesIdx || len_inc == NodesIdx) begin
            // Bad pointer or a full graph's worth of hops without reaching src.
            err_loop_d = 1'b1;
            state_d    = StFinish;
          end else begin
            cur_d = nxt;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dest_q       <= '0;
      parent_q     <= '0;
      dist_q       <= '0;
      cur_q        <= '0;
      path_len_q   <= '0;
      total_dist_q <= '0;
      err_unr_q    <= 1'b0;
      err_loop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dest_q       <= dest_d;
      parent_q     <= parent_d;
      dist_q       <= dist_d;
      cur_q        <= cur_d;
      path_len_q   <= path_len_d;
      total_dist_q <= total_dist_d;
      err_unr_q    <= err_unr_d;
      err_loop_q   <= err_loop_d;
    end
  end

  always_comb begin
    busy            = (state_q != StIdle);
    node_valid      = (state_q == StEmit);
    node_id         = node_valid ? cur_q : '0;
    node_last       = node_valid && (cur_q == src_q);
    done            = (state_q == StFinish);
    path_len        = path_len_q;
    total_dist      = total_dist_q;
    err_unreachable = err_unr_q;
    err_loop        = err_loop_q;
  end

endmodule

// File: tb/tb_path_tracer.sv
// Directed bench for path_tracer: table of traces over a fixed 9-node graph plus
// hand sequences for stalls, start-while-busy and mid-trace reset.
module tb_path_tracer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  src, dest;
  logic [35:0] parent_flat;
  logic [71:0] dist_flat;
  logic        busy, node_valid, node_ready, node_last, done;
  logic [3:0]  node_id, path_len;
  logic [7:0]  total_dist;
  logic        err_unreachable, err_loop;

  int errors = 0;
  int checks = 0;

  path_tracer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .src             (src),
    .dest            (dest),
    .parent_flat     (parent_flat),
    .dist_flat       (dist_flat),
    .busy            (busy),
    .node_valid      (node_valid),
    .node_ready      (node_ready),
    .node_id         (node_id),
    .node_last       (node_last),
    .done            (done),
    .path_len        (path_len),
    .total_dist      (total_dist),
    .err_unreachable (err_unreachable),
    .err_loop        (err_loop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int src;
    int dest;
    int pi;      // parent index to override (-1 none)
    int pv;
    int di;      // distance index to override (-1 none)
    int dv;
    int n;       // expected node count
    int exp [9];
    int exp_dist;
    int eu;
    int el;
  } vec_t;

  int base_par [9] = '{1, 4, 1, 6, 7, 4, 15, 6, 7};
  int base_dist[9] = '{9, 8, 11, 1, 4, 9, 0, 3, 7};

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    int p, d;
    src  = v.src[3:0];
    dest = v.dest[3:0];
    for (int i = 0; i < 9; i++) begin
      p = (i == v.pi) ? v.pv : base_par[i];
      d = (i == v.di) ? v.dv : base_dist[i];
      parent_flat[i*4 +: 4] = p[3:0];
      dist_flat[i*8 +: 8]   = d[7:0];
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic run(input vec_t v, input int mode, input string nm);
    int cnt, first_valid, hs_cyc, cyc;
    bit got_done, stalled, rdy;
    logic [3:0] hold_id;
    logic hold_last;
    load(v);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, ".busy_after_start"}, busy, 1);
    cnt = 0; first_valid = -1; hs_cyc = -1; got_done = 0; stalled = 0;
    hold_id = '0; hold_last = 1'b0;
    for (cyc = 0; cyc < 60 && !got_done; cyc++) begin
      if (stalled) begin
        chk({nm, ".stall_valid"}, node_valid, 1);
        chk({nm, ".stall_id"}, node_id, hold_id);
        chk({nm, ".stall_last"}, node_last, hold_last);
      end
      if (node_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        got_done = 1;
        chk({nm, ".count"}, cnt, v.n);
        chk({nm, ".path_len"}, path_len, v.n);
        chk({nm, ".total_dist"}, total_dist, v.exp_dist);
        chk({nm, ".err_unreachable"}, err_unreachable, v.eu);
        chk({nm, ".err_loop"}, err_loop, v.el);
        chk({nm, ".valid_at_done"}, node_valid, 0);
        if (v.n > 0) begin
          chk({nm, ".first_valid_cyc"}, first_valid, 1);
          chk({nm, ".done_cyc"}, cyc, hs_cyc + 1);
        end else begin
          chk({nm, ".no_valid"}, first_valid, -1);
          chk({nm, ".done_cyc"}, cyc, 1);
        end
      end else begin
        rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
        node_ready = rdy;
        stalled = node_valid && !rdy;
        hold_id = node_id;
        hold_last = node_last;
        if (node_valid && rdy) begin
          if (cnt < 9) begin
            chk({nm, ".node_id"}, node_id, v.exp[cnt]);
            chk({nm, ".node_last"}, node_last, (v.exp[cnt] == v.src) ? 1 : 0);
          end else begin
            chk({nm, ".extra_node"}, cnt, 8);
          end
          cnt++;
          hs_cyc = cyc;
        end
        step();
      end
    end
    if (!got_done) chk({nm, ".done_timeout"}, 0, 1);
    step();
    chk({nm, ".busy_after_done"}, busy, 0);
    chk({nm, ".done_pulse"}, done, 0);
    chk({nm, ".len_hold"}, path_len, v.n);
    chk({nm, ".dist_hold"}, total_dist, v.exp_dist);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; node_ready = 1'b0;
    src = '0; dest = '0; parent_flat = '0; dist_flat = '0;

    vecs[0] = '{6, 2, -1, 0, -1, 0, 5, '{2, 1, 4, 7, 6, 0, 0, 0, 0}, 11, 0, 0};
    vecs[1] = '{6, 6, -1, 0, -1, 0, 1, '{6, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0};
    vecs[2] = '{6, 2, -1, 0, 2, 100, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1, 0};
    vecs[3] = '{6, 9, -1, 0, -1, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1, 0};
    vecs[4] = '{6, 2, 4, 1, -1, 0, 9, '{2, 1, 4, 1, 4, 1, 4, 1, 4}, 11, 0, 1};
    vecs[5] = '{6, 2, 4, 15, -1, 0, 3, '{2, 1, 4, 0, 0, 0, 0, 0, 0}, 11, 0, 1};

    #2;
    chk("reset.busy", busy, 0);
    chk("reset.valid", node_valid, 0);
    chk("reset.done", done, 0);
    chk("reset.path_len", path_len, 0);
    chk("reset.errs", {err_unreachable, err_loop}, 0);
    #10 rst = 1'b0;
    step();

    for (int k = 0; k < 6; k++) run(vecs[k], 0, $sformatf("vec%0d", k));

    run(vecs[0], 1, "stall");

    // Start while busy is ignored, then reset mid-EMIT after two nodes.
    load(vecs[0]);
    node_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("seq.node0", node_id, 2);
    step();
    chk("seq.node1", node_id, 1);
    load(vecs[1]);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("seq.busy_start_ignored", node_id, 4);
    chk("seq.busy_still", busy, 1);
    node_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.valid", node_valid, 0);
    chk("rst.node_id", node_id, 0);
    chk("rst.done", done, 0);
    chk("rst.path_len", path_len, 0);
    chk("rst.total_dist", total_dist, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst.no_done", {done, busy}, 0);
    end

    run(vecs[0], 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/path_tracer.md
Name: path_tracer

Overview:
- Sequential back-tracer that sits directly downstream of the shortest-path (Dijkstra) engine.
- On a start pulse it snapshots the engine's per-node distance and parent arrays for the 9-node graph. It then walks parent pointers from destination back to source.
- Emits one node index per valid/ready handshake, in dest-to-src order. Reports path length, total distance and error flags.
- Replaces the behavioural path printer with synthesizable hardware feeding a display/UART stage.

Parameters:
N_NODES, 9, number of graph nodes
IDX_W, 4, node index width; all-ones (15) encodes "no parent"
DIST_W, 8, distance width
INF_DIST, 100, distance value meaning unreachable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; request a trace (ignored while busy=1)
src  in  IDX_W  source node index
dest  in  IDX_W  destination node index
parent_flat  in  N_NODES*IDX_W  parent[i] at bits [i*IDX_W +: IDX_W]
dist_flat  in  N_NODES*DIST_W  distance[i] at bits [i*DIST_W +: DIST_W]
busy  out  1  high from the cycle after accepted start until done
node_valid  out  1  node_id/node_last valid
node_ready  in  1  consumer accepts node
node_id  out  IDX_W  current path node
node_last  out  1  node_id == src (final node of path)
done  out  1  one-cycle pulse at end of trace (success or error)
path_len  out  IDX_W  number of nodes emitted
total_dist  out  DIST_W  distance[dest]
err_unreachable  out  1  dest unreachable or src/dest index out of range
err_loop  out  1  invalid parent pointer or hop limit exceeded

Behaviour:
- Reset: all outputs 0, FSM = IDLE, internal snapshot registers cleared. Reset mid-trace aborts immediately; no done pulse is issued.
- FSM states: IDLE, CHECK, EMIT, FINISH.
- IDLE, start=1:
  - Register src, dest, parent_flat and dist_flat (upstream may change them afterwards).
  - Clear path_len, err_*, total_dist.
  - Go to CHECK; busy=1 next cycle.
- CHECK (1 cycle):
  - If src>=N_NODES, dest>=N_NODES, or dist[dest]>=INF_DIST: set err_unreachable, go to FINISH.
  - Otherwise: total_dist<=dist[dest], cur<=dest, go to EMIT.
- EMIT:
  - node_valid=1, node_id=cur, node_last=(cur==src). Outputs are held stable while node_ready=0.
  - On handshake (valid&ready), path_len increments.
  - If node_last: go to FINISH.
  - Else nxt=parent[cur]. If nxt>=N_NODES, or path_len+1==N_NODES (hop limit): set err_loop, go to FINISH. Otherwise cur<=nxt and stay in EMIT.
- FINISH (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- done coincides with final results. path_len, total_dist and err_* hold until the next accepted start.
- Latency: start at cycle T gives first node_valid at T+2. With node_ready tied high, one node per cycle. done arrives one cycle after the last handshake.
- src==dest with dist[dest]==0: emits one node with node_last=1, path_len=1, total_dist=0.
- start asserted while busy is ignored. start in the same cycle as done (FSM in FINISH) is also ignored.
- Arithmetic: path_len saturates logically at N_NODES via the hop limit; it never wraps. No distance arithmetic is performed; the stored value is passed through.

Test Plan:
1. parent=[1,4,1,6,7,4,15,6,7], dist=[9,8,11,1,4,9,0,3,7], src=6, dest=2, ready=1 -> node stream 2,1,4,7,6 (last on 6); path_len=5, total_dist=11, no errors; first valid 2 cycles after start, done 1 cycle after node 6.
2. Same arrays, ready toggled 1-0-0-1... -> identical stream; node_id/node_last held stable during stalls; no duplicate or dropped nodes.
3. src=dest=6 -> single node 6 with node_last=1; path_len=1, total_dist=0.
4. dist[2]=100, dest=2 -> no node_valid; done 2 cycles after start, err_unreachable=1, path_len=0. Separately, dest=9 -> same response.
5. parent[1]=4, parent[4]=1, src=6, dest=2, dist[2]=11 -> emits 2,1,4,1,4,... until 9 nodes; err_loop=1, path_len=9. Separately, parent[4]=15 -> err_loop after node 4.
6. Assert rst while in EMIT after 2 nodes -> all outputs 0 asynchronously, no done. A new start after reset completes normally. A start pulse during busy has no effect.
